// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port ids, latched command.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wren;
        logic [3:0]  mask;
    } cmd_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant: purely combinational, one-hot (or zero) grant, no state of its own.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  port_id_t last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            // Contest goes to whichever port did not win last time.
            grant = (last_grant == PORT1) ? 2'b01 : 2'b10;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter, one transaction in flight; accept->cmd 1 cycle, completion->response 1 cycle.
// Requesters are back-pressured (rdy low) from accept until the response cycle; memory wait bounded by TIMEOUT.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_p0_vld,
    output logic        o_p0_rdy,
    input  logic [31:0] i_p0_addr,
    input  logic [31:0] i_p0_wdata,
    input  logic        i_p0_wren,
    input  logic [3:0]  i_p0_mask,
    output logic        o_p0_rsp_vld,
    output logic [31:0] o_p0_rdata,
    output logic        o_p0_err,

    input  logic        i_p1_vld,
    output logic        o_p1_rdy,
    input  logic [31:0] i_p1_addr,
    input  logic [31:0] i_p1_wdata,
    input  logic        i_p1_wren,
    input  logic [3:0]  i_p1_mask,
    output logic        o_p1_rsp_vld,
    output logic [31:0] o_p1_rdata,
    output logic        o_p1_err,

    output logic        o_mem_vld,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_wren,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_rvld,
    input  logic [31:0] i_mem_rdata,

    output logic        o_busy
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t          state, state_nxt;
    port_id_t        last_grant, owner;
    cmd_t            cmd, p0_cmd, p1_cmd;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]      grant;
    logic            accept, done, timeout, active;
    logic            rsp_vld, rsp_err;
    logic [31:0]     rsp_rdata;

    assign p0_cmd = '{addr: i_p0_addr, wdata: i_p0_wdata, wren: i_p0_wren, mask: i_p0_mask};
    assign p1_cmd = '{addr: i_p1_addr, wdata: i_p1_wdata, wren: i_p1_wren, mask: i_p1_mask};
    assign active = !i_reset;

    rr_arbiter2 u_rr (
        .req0       (i_p0_vld),
        .req1       (i_p1_vld),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        done         = 1'b0;
        timeout      = 1'b0;
        o_p0_rdy     = 1'b0;
        o_p1_rdy     = 1'b0;
        o_mem_vld    = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_wren   = 1'b0;
        o_mem_mask   = '0;
        o_busy       = active && (state != IDLE);
        o_p0_rsp_vld = active && rsp_vld && (owner == PORT0);
        o_p1_rsp_vld = active && rsp_vld && (owner == PORT1);
        o_p0_rdata   = o_p0_rsp_vld ? rsp_rdata : '0;
        o_p1_rdata   = o_p1_rsp_vld ? rsp_rdata : '0;
        o_p0_err     = o_p0_rsp_vld && rsp_err;
        o_p1_err     = o_p1_rsp_vld && rsp_err;
        case (state)
            IDLE: begin
                o_p0_rdy = active && grant[0];
                o_p1_rdy = active && grant[1];
                accept   = o_p0_rdy || o_p1_rdy;
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                o_mem_vld   = active;
                o_mem_addr  = active ? cmd.addr  : '0;
                o_mem_wdata = active ? cmd.wdata : '0;
                o_mem_wren  = active && cmd.wren;
                o_mem_mask  = active ? cmd.mask  : '0;
                state_nxt   = WAIT;
            end
            WAIT: begin
                // A completion in the final wait cycle beats the timeout.
                if (i_mem_rvld) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_grant <= PORT1;
            owner      <= PORT0;
            cmd        <= '0;
            wait_cnt   <= '0;
            rsp_vld    <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp_vld   <= done || timeout;
            rsp_err   <= timeout;
            rsp_rdata <= done ? i_mem_rdata : '0;
            if (accept) begin
                owner      <= grant[1] ? PORT1 : PORT0;
                last_grant <= grant[1] ? PORT1 : PORT0;
                cmd        <= grant[1] ? p1_cmd : p0_cmd;
            end
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT=4; inputs driven 2 time units after each rising edge.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_p0_vld, i_p1_vld, i_p0_wren, i_p1_wren, i_mem_rvld;
    logic [31:0] i_p0_addr, i_p0_wdata, i_p1_addr, i_p1_wdata, i_mem_rdata;
    logic [3:0]  i_p0_mask, i_p1_mask;
    logic        o_p0_rdy, o_p1_rdy, o_p0_rsp_vld, o_p1_rsp_vld, o_p0_err, o_p1_err;
    logic [31:0] o_p0_rdata, o_p1_rdata;
    logic        o_mem_vld, o_mem_wren, o_busy;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_p0_vld     (i_p0_vld),
        .o_p0_rdy     (o_p0_rdy),
        .i_p0_addr    (i_p0_addr),
        .i_p0_wdata   (i_p0_wdata),
        .i_p0_wren    (i_p0_wren),
        .i_p0_mask    (i_p0_mask),
        .o_p0_rsp_vld (o_p0_rsp_vld),
        .o_p0_rdata   (o_p0_rdata),
        .o_p0_err     (o_p0_err),
        .i_p1_vld     (i_p1_vld),
        .o_p1_rdy     (o_p1_rdy),
        .i_p1_addr    (i_p1_addr),
        .i_p1_wdata   (i_p1_wdata),
        .i_p1_wren    (i_p1_wren),
        .i_p1_mask    (i_p1_mask),
        .o_p1_rsp_vld (o_p1_rsp_vld),
        .o_p1_rdata   (o_p1_rdata),
        .o_p1_err     (o_p1_err),
        .o_mem_vld    (o_mem_vld),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wren   (o_mem_wren),
        .o_mem_mask   (o_mem_mask),
        .i_mem_rvld   (i_mem_rvld),
        .i_mem_rdata  (i_mem_rdata),
        .o_busy       (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        i_reset = 1'b1;
        i_p0_vld = 0; i_p0_addr = 0; i_p0_wdata = 0; i_p0_wren = 0; i_p0_mask = 0;
        i_p1_vld = 0; i_p1_addr = 0; i_p1_wdata = 0; i_p1_wren = 0; i_p1_mask = 0;
        i_mem_rvld = 0; i_mem_rdata = 0;
        tick();
        tick();

        // Reset state: requests ignored, every output low.
        i_p0_vld = 1; i_p1_vld = 1;
        settle();
        chk("rst_p0_rdy", o_p0_rdy, 0);
        chk("rst_p1_rdy", o_p1_rdy, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_mem_vld", o_mem_vld, 0);
        chk("rst_p0_rsp", o_p0_rsp_vld, 0);
        i_p0_vld = 0; i_p1_vld = 0;
        tick();
        i_reset = 0;

        // p0 read, completion two cycles after the command.
        i_p0_vld = 1; i_p0_addr = 32'h0000_2000; i_p0_wren = 0; i_p0_mask = 4'hF;
        settle();
        chk("rd_p0_rdy", o_p0_rdy, 1);
        chk("rd_p1_rdy", o_p1_rdy, 0);
        chk("rd_idle_busy", o_busy, 0);
        tick();
        i_p0_vld = 0; i_p0_addr = 0;
        settle();
        chk("rd_mem_vld", o_mem_vld, 1);
        chk("rd_mem_addr", o_mem_addr, 32'h0000_2000);
        chk("rd_mem_wren", o_mem_wren, 0);
        chk("rd_issue_busy", o_busy, 1);
        chk("rd_issue_rdy", o_p0_rdy, 0);
        tick();
        settle();
        chk("rd_wait_mem_vld", o_mem_vld, 0);
        chk("rd_wait_busy", o_busy, 1);
        tick();
        i_mem_rvld = 1; i_mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("rd_early_rsp", o_p0_rsp_vld, 0);
        tick();
        i_mem_rvld = 0; i_mem_rdata = 0;
        settle();
        chk("rd_rsp_vld", o_p0_rsp_vld, 1);
        chk("rd_rsp_data", o_p0_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_err", o_p0_err, 0);
        chk("rd_p1_rsp_vld", o_p1_rsp_vld, 0);
        chk("rd_p1_rdata", o_p1_rdata, 0);
        chk("rd_rsp_busy", o_busy, 0);
        tick();
        settle();
        chk("rd_rsp_one_cycle", o_p0_rsp_vld, 0);
        chk("rd_rdata_zero", o_p0_rdata, 0);

        // Round-robin from reset with both requesters held valid: 0,1,0,1.
        i_reset = 1;
        tick();
        i_reset = 0;
        i_p0_vld = 1; i_p1_vld = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("rr%0d_p0_rdy", k), o_p0_rdy, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_p1_rdy", k), o_p1_rdy, (k % 2 == 1) ? 1 : 0);
            tick();
            settle();
            chk($sformatf("rr%0d_issue_rdy", k), {o_p0_rdy, o_p1_rdy}, 0);
            tick();
            i_mem_rvld = 1; i_mem_rdata = 32'h100 + k;
            settle();
            chk($sformatf("rr%0d_wait_rdy", k), {o_p0_rdy, o_p1_rdy}, 0);
            tick();
            i_mem_rvld = 0; i_mem_rdata = 0;
            settle();
            chk($sformatf("rr%0d_rsp_p0", k), o_p0_rsp_vld, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_rsp_p1", k), o_p1_rsp_vld, (k % 2 == 1) ? 1 : 0);
            if (k == 3) begin
                chk("rr3_rdata", o_p1_rdata, 32'h103);
            end
        end
        i_p0_vld = 0; i_p1_vld = 0;
        tick();

        // p1 masked write.
        i_p1_vld = 1; i_p1_addr = 32'h0000_7000; i_p1_wdata = 32'h1234_5678;
        i_p1_wren = 1; i_p1_mask = 4'b0011;
        settle();
        chk("wr_p1_rdy", o_p1_rdy, 1);
        tick();
        i_p1_vld = 0; i_p1_addr = 0; i_p1_wdata = 0; i_p1_wren = 0; i_p1_mask = 0;
        settle();
        chk("wr_mem_vld", o_mem_vld, 1);
        chk("wr_mem_addr", o_mem_addr, 32'h0000_7000);
        chk("wr_mem_wdata", o_mem_wdata, 32'h1234_5678);
        chk("wr_mem_wren", o_mem_wren, 1);
        chk("wr_mem_mask", o_mem_mask, 4'b0011);
        tick();
        settle();
        chk("wr_single_pulse", o_mem_vld, 0);
        chk("wr_addr_cleared", o_mem_addr, 0);
        chk("wr_wait_busy", o_busy, 1);
        i_mem_rvld = 1;
        tick();
        i_mem_rvld = 0;
        settle();
        chk("wr_p1_rsp", o_p1_rsp_vld, 1);
        chk("wr_p1_err", o_p1_err, 0);
        chk("wr_p0_rsp", o_p0_rsp_vld, 0);
        tick();

        // p0 read with no completion: error response after 4 WAIT cycles.
        i_p0_vld = 1; i_p0_addr = 32'h0000_3000;
        tick();
        i_p0_vld = 0;
        tick();
        for (int w = 0; w < 4; w++) begin
            settle();
            chk($sformatf("to_w%0d_rsp", w), o_p0_rsp_vld, 0);
            chk($sformatf("to_w%0d_busy", w), o_busy, 1);
            tick();
        end
        settle();
        chk("to_rsp_vld", o_p0_rsp_vld, 1);
        chk("to_rsp_err", o_p0_err, 1);
        chk("to_rsp_rdata", o_p0_rdata, 0);
        chk("to_busy", o_busy, 0);
        tick();
        i_mem_rvld = 1; i_mem_rdata = 32'hFFFF_FFFF;
        tick();
        i_mem_rvld = 0; i_mem_rdata = 0;
        settle();
        chk("to_stray_p0", o_p0_rsp_vld, 0);
        chk("to_stray_p1", o_p1_rsp_vld, 0);
        chk("to_stray_busy", o_busy, 0);

        // Completion in the last WAIT cycle beats the timeout.
        i_p0_vld = 1;
        tick();
        i_p0_vld = 0;
        tick();
        tick();
        tick();
        tick();
        i_mem_rvld = 1; i_mem_rdata = 32'hCAFE_F00D;
        tick();
        i_mem_rvld = 0; i_mem_rdata = 0;
        settle();
        chk("race_rsp_vld", o_p0_rsp_vld, 1);
        chk("race_rsp_err", o_p0_err, 0);
        chk("race_rsp_data", o_p0_rdata, 32'hCAFE_F00D);
        tick();

        // Reset during WAIT abandons the transaction; later completion ignored.
        i_p0_vld = 1;
        tick();
        i_p0_vld = 0;
        tick();
        i_reset = 1;
        settle();
        chk("rw_busy_in_reset", o_busy, 0);
        tick();
        i_reset = 0;
        i_mem_rvld = 1; i_mem_rdata = 32'h1111_1111;
        settle();
        chk("rw_busy_after", o_busy, 0);
        tick();
        i_mem_rvld = 0; i_mem_rdata = 0;
        settle();
        chk("rw_no_rsp_p0", o_p0_rsp_vld, 0);
        chk("rw_no_rsp_p1", o_p1_rsp_vld, 0);
        i_p0_vld = 1; i_p1_vld = 1;
        settle();
        chk("rw_p0_wins", o_p0_rdy, 1);
        chk("rw_p1_loses", o_p1_rdy, 0);
        i_p0_vld = 0; i_p1_vld = 0;
        tick();

        // Back-to-back p0 at minimum latency: accepts three cycles apart.
        i_p0_vld = 1; i_p0_addr = 32'h0000_4000;
        settle();
        chk("b2b_acc1", o_p0_rdy, 1);
        tick();
        i_p0_addr = 32'h0000_4004;
        settle();
        chk("b2b_t1_rdy", o_p0_rdy, 0);
        chk("b2b_t1_mem_addr", o_mem_addr, 32'h0000_4000);
        tick();
        i_mem_rvld = 1; i_mem_rdata = 32'hAAAA_0001;
        settle();
        chk("b2b_t2_rdy", o_p0_rdy, 0);
        tick();
        i_mem_rvld = 0; i_mem_rdata = 0;
        settle();
        chk("b2b_t3_rsp", o_p0_rsp_vld, 1);
        chk("b2b_t3_acc2", o_p0_rdy, 1);
        tick();
        i_p0_vld = 0;
        settle();
        chk("b2b_t4_mem_vld", o_mem_vld, 1);
        chk("b2b_t4_mem_addr", o_mem_addr, 32'h0000_4004);
        tick();
        i_mem_rvld = 1; i_mem_rdata = 32'hAAAA_0002;
        tick();
        i_mem_rvld = 0; i_mem_rdata = 0;
        settle();
        chk("b2b_t6_rsp", o_p0_rsp_vld, 1);
        chk("b2b_t6_data", o_p0_rdata, 32'hAAAA_0002);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
